// File: rtl/biu_port.sv
// biu_port: bus interface responder for the execution unit's
// cs_biu / sel / op_sel / ready_biu handshake on the shared tri-state bus.
//
// It serves operand reads from an 8x16 register file or a 16x16 data memory
// and commits one result write-back per transaction. WAIT_CYC wait states
// are inserted at the start of every transaction.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   ir         current instruction (dst, src1, src2 and maddr fields)
//   cs_biu     chip select; only a clean 1 counts as asserted
//   sel        target select (10 register file, 01 data memory), sampled at start
//   op_sel     phase (00 read A, 01 read B, 10 write, 11 reserved)
//   bus        shared data bus; driven only while serving a read
//   ready_biu  registered ready
//   err        sticky protocol-error flag, cleared only by rst
//
// Configuration macro:
//   BIU_R0_ZERO_EN  when defined, rf[0] is hard-wired to zero and writes to
//                   dst=0 are silently discarded.

module biu_port #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        cs_biu,
    input  logic [1:0]  sel,
    input  logic [1:0]  op_sel,
    inout  wire  [15:0] bus,
    output logic        ready_biu,
    output logic        err
);

    localparam logic [1:0] SelRf  = 2'b10;
    localparam logic [1:0] SelMem = 2'b01;
    localparam logic [1:0] OpRdA  = 2'b00;
    localparam logic [1:0] OpRdB  = 2'b01;
    localparam logic [1:0] OpWr   = 2'b10;
    localparam logic [1:0] OpRsv  = 2'b11;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StServe,
        StWdone
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  sel_q;
    logic [15:0] rf_q  [8];
    logic [15:0] mem_q [16];

    logic        cs_on;
    logic [2:0]  dst;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [3:0]  maddr;
    logic        rf_wr_ok;
    logic        rf_we;
    logic        mem_we;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        unused_ir;

    // X and Z on the select must not start or advance a transaction.
    assign cs_on = (cs_biu === 1'b1);

    assign dst   = ir[26:24];
    assign src1  = ir[23:21];
    assign src2  = ir[13:11];
    assign maddr = ir[30:27];

    assign unused_ir = ^{ir[31], ir[20:14], ir[10:0]};

`ifdef BIU_R0_ZERO_EN
    // rf[0] is never written, so it keeps its reset value of zero for reads.
    assign rf_wr_ok = (dst != 3'd0);
`else
    assign rf_wr_ok = 1'b1;
`endif

    // Reserved sel_q values fall through both enables: the write is dropped.
    assign rf_we  = (state_q == StServe) && cs_on && (op_sel == OpWr) &&
                    (sel_q == SelRf) && rf_wr_ok;
    assign mem_we = (state_q == StServe) && cs_on && (op_sel == OpWr) &&
                    (sel_q == SelMem);

    // Zero-latency read path; reserved sel_q returns zero so the EU never hangs.
    always_comb begin
        rd_en   = 1'b0;
        rd_data = 16'h0000;
        if ((state_q == StServe) && cs_on) begin
            case (op_sel)
                OpRdA: begin
                    rd_en = 1'b1;
                    if (sel_q == SelRf) begin
                        rd_data = rf_q[src1];
                    end else if (sel_q == SelMem) begin
                        rd_data = mem_q[maddr];
                    end
                end
                OpRdB: begin
                    rd_en = 1'b1;
                    if ((sel_q == SelRf) || (sel_q == SelMem)) begin
                        rd_data = rf_q[src2];
                    end
                end
                default: begin
                    rd_en = 1'b0;
                end
            endcase
        end
    end

    // state_q resets asynchronously, so the drive releases as soon as rst rises.
    assign bus = rd_en ? rd_data : 16'hzzzz;

    // Storage; the write commits at the end of the transaction, so reads
    // within the same transaction see the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            if (rf_we) begin
                rf_q[dst] <= bus;
            end
            if (mem_we) begin
                mem_q[maddr] <= bus;
            end
        end
    end

    // Control FSM with registered ready and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            sel_q     <= SelRf;
            ready_biu <= 1'b1;
            err       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cs_on) begin
                        sel_q <= sel;
                        cnt_q <= WaitLoad;
                        if (sel[1] == sel[0]) begin
                            err <= 1'b1;
                        end
                        if (WaitLoad == 4'd0) begin
                            state_q   <= StServe;
                            ready_biu <= 1'b1;
                        end else begin
                            state_q   <= StWait;
                            ready_biu <= 1'b0;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    // <= guards against a stuck counter should it ever hold 0.
                    if (cnt_q <= 4'd1) begin
                        state_q   <= StServe;
                        ready_biu <= 1'b1;
                    end
                end
                StServe: begin
                    ready_biu <= 1'b1;
                    if (cs_on) begin
                        if (op_sel == OpWr) begin
                            state_q <= StWdone;
                        end else if (op_sel == OpRsv) begin
                            err <= 1'b1;
                        end
                    end
                end
                StWdone: begin
                    ready_biu <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    ready_biu <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
